// File: rtl/core_if_fetch_ctrl.sv
// Instruction-fetch sequencer: issues sequential word fetches within a prefetch
// window ahead of decode, and writes returned words into the IF shift buffer.
module core_if_fetch_ctrl #(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                 clk,
    input  logic                                 rest,
    input  logic                                 redirect,
    input  logic [31:0]                          redirect_pc,
    input  logic [31:0]                          cur_pc,
    output logic                                 bus_req,
    output logic [31:0]                          bus_addr,
    input  logic                                 bus_ack,
    input  logic                                 bus_rvalid,
    input  logic [31:0]                          bus_rdata,
    output logic                                 buf_write,
    output logic [31:0]                          buf_addr,
    output logic [31:0]                          buf_data,
    output logic                                 buf_clear,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

    localparam int unsigned OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] WINDOW  = 32'(DEPTH * 4);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [31:0]   fetch_pc_r, fetch_pc_nxt_s;
    logic [31:0]   resp_pc_r, resp_pc_nxt_s;
    logic [OW-1:0] outst_r, outst_nxt_s;
    logic [OW-1:0] discard_r, discard_nxt_s;
    logic          wr_r, wr_nxt_s;
    logic [31:0]   wr_addr_r, wr_addr_nxt_s;
    logic [31:0]   wr_data_r, wr_data_nxt_s;
    logic          clear_r, clear_nxt_s;

    logic [31:0]   pc_al_s;
    logic          win_ok_s;
    logic          issue_s;
    logic          fire_s;
    logic          rsp_s;
    logic [OW-1:0] remain_s;

    // Window distance is modular so the check stays correct across address wrap.
    assign pc_al_s  = {redirect_pc[31:2], 2'b00};
    assign win_ok_s = (fetch_pc_r - cur_pc) < WINDOW;
    assign issue_s  = (state_r == RUN) && !redirect && (outst_r < MAX_OUT) && win_ok_s;
    assign fire_s   = issue_s && bus_ack;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_s    = bus_rvalid && (outst_r != {OW{1'b0}});
    assign remain_s = outst_r - (rsp_s ? OW'(1) : OW'(0));

    assign bus_req     = issue_s;
    assign bus_addr    = fetch_pc_r;
    assign buf_write   = wr_r;
    assign buf_addr    = wr_addr_r;
    assign buf_data    = wr_data_r;
    assign buf_clear   = clear_r;
    assign outstanding = outst_r;

    // Next-state, counter and buffer-write computation.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        resp_pc_nxt_s  = resp_pc_r;
        outst_nxt_s    = outst_r;
        discard_nxt_s  = discard_r;
        wr_nxt_s       = 1'b0;
        wr_addr_nxt_s  = wr_addr_r;
        wr_data_nxt_s  = wr_data_r;
        clear_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_nxt_s = pc_al_s;
                    resp_pc_nxt_s  = pc_al_s;
                    clear_nxt_s    = 1'b1;
                    state_nxt_s    = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN, DRAIN: begin
                if (redirect) begin
                    fetch_pc_nxt_s = pc_al_s;
                    resp_pc_nxt_s  = pc_al_s;
                    clear_nxt_s    = 1'b1;
                    outst_nxt_s    = remain_s;
                    if (remain_s == {OW{1'b0}}) begin
                        discard_nxt_s = {OW{1'b0}};
                        state_nxt_s   = RUN;
                    end else begin
                        discard_nxt_s = remain_s;
                        state_nxt_s   = DRAIN;
                    end
                end else if (state_r == RUN) begin
                    fetch_pc_nxt_s = fire_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
                    if (rsp_s) begin
                        wr_nxt_s      = 1'b1;
                        wr_addr_nxt_s = resp_pc_r;
                        wr_data_nxt_s = bus_rdata;
                        resp_pc_nxt_s = resp_pc_r + 32'd4;
                    end else begin
                        resp_pc_nxt_s = resp_pc_r;
                    end
                    case ({fire_s, rsp_s})
                        2'b10:   outst_nxt_s = outst_r + OW'(1);
                        2'b01:   outst_nxt_s = outst_r - OW'(1);
                        default: outst_nxt_s = outst_r;
                    endcase
                end else begin
                    if (rsp_s) begin
                        discard_nxt_s = discard_r - OW'(1);
                        outst_nxt_s   = outst_r - OW'(1);
                        if (discard_r == OW'(1)) begin
                            state_nxt_s = RUN;
                        end else begin
                            state_nxt_s = DRAIN;
                        end
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rest) begin
            state_r    <= IDLE;
            fetch_pc_r <= 32'd0;
            resp_pc_r  <= 32'd0;
            outst_r    <= {OW{1'b0}};
            discard_r  <= {OW{1'b0}};
            wr_r       <= 1'b0;
            wr_addr_r  <= 32'd0;
            wr_data_r  <= 32'd0;
            clear_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            resp_pc_r  <= resp_pc_nxt_s;
            outst_r    <= outst_nxt_s;
            discard_r  <= discard_nxt_s;
            wr_r       <= wr_nxt_s;
            wr_addr_r  <= wr_addr_nxt_s;
            wr_data_r  <= wr_data_nxt_s;
            clear_r    <= clear_nxt_s;
        end
    end

endmodule

// File: tb/tb_core_if_fetch_ctrl.sv
// Bench for core_if_fetch_ctrl: directed cycle sequence with a scoreboard of
// expected buffer writes (address, data, cycle) checked by a negedge monitor.
module tb_core_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rest;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] cur_pc;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        buf_write;
    logic [31:0] buf_addr;
    logic [31:0] buf_data;
    logic        buf_clear;
    logic [1:0]  outstanding;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    core_if_fetch_ctrl #(.DEPTH(2), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rest(rest), .redirect(redirect), .redirect_pc(redirect_pc),
        .cur_pc(cur_pc), .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .buf_write(buf_write),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_clear(buf_clear),
        .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Push an expected write and drive the matching response this cycle.
    task automatic respond(input logic [31:0] a, input logic [31:0] d, input bit keep);
        bus_rvalid = 1'b1;
        bus_rdata  = d;
        if (keep) sb_q.push_back('{a: a, d: d, c: cyc + 1});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req"},   {31'd0, bus_req},   32'd0);
        check_val({tag, "_addr"},  bus_addr,           32'd0);
        check_val({tag, "_wr"},    {31'd0, buf_write}, 32'd0);
        check_val({tag, "_baddr"}, buf_addr,           32'd0);
        check_val({tag, "_bdata"}, buf_data,           32'd0);
        check_val({tag, "_clr"},   {31'd0, buf_clear}, 32'd0);
        check_val({tag, "_out"},   {30'd0, outstanding}, 32'd0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (buf_write === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("unexp_write", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("wr_addr", buf_addr, e.a);
                check_val("wr_data", buf_data, e.d);
                check_val("wr_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        rest = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; cur_pc = 32'd0;
        bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        repeat (3) nxt();
        check_reset_outputs("rst");
        rest = 1'b0;
        nxt();
        #1 check_val("idle_req", {31'd0, bus_req}, 32'd0);

        // Redirect from IDLE with unaligned target, window of two words.
        redirect = 1'b1; redirect_pc = 32'h0000_1003; cur_pc = 32'h0000_1000; bus_ack = 1'b1;
        #1 check_val("redir_cyc_req", {31'd0, bus_req}, 32'd0);
        nxt();
        redirect = 1'b0;
        #1;
        check_val("clr1", {31'd0, buf_clear}, 32'd1);
        check_val("req1", {31'd0, bus_req}, 32'd1);
        check_val("addr1", bus_addr, 32'h0000_1000);
        nxt();
        respond(32'h0000_1000, 32'hAAAA_0001, 1'b1);
        #1;
        check_val("clr1_off", {31'd0, buf_clear}, 32'd0);
        check_val("req2", {31'd0, bus_req}, 32'd1);
        check_val("addr2", bus_addr, 32'h0000_1004);
        nxt();
        respond(32'h0000_1004, 32'hAAAA_0002, 1'b1);
        #1;
        check_val("win_block", {31'd0, bus_req}, 32'd0);
        check_val("out_a", {30'd0, outstanding}, 32'd1);
        nxt();
        bus_rvalid = 1'b0;
        #1;
        check_val("out_b", {30'd0, outstanding}, 32'd0);
        check_val("win_hold", {31'd0, bus_req}, 32'd0);
        cur_pc = 32'h0000_1004;
        #1;
        check_val("req3", {31'd0, bus_req}, 32'd1);
        check_val("addr3", bus_addr, 32'h0000_1008);
        nxt();
        cur_pc = 32'h0000_1008;
        #1 check_val("addr4", bus_addr, 32'h0000_100C);
        nxt();
        cur_pc = 32'h0000_100C;
        #1;
        check_val("out_two", {30'd0, outstanding}, 32'd2);
        check_val("credit_block", {31'd0, bus_req}, 32'd0);

        // Redirect with two outstanding: drain both silently.
        redirect = 1'b1; redirect_pc = 32'h0000_2000; cur_pc = 32'h0000_2000;
        nxt();
        redirect = 1'b0;
        respond(32'h0, 32'hDEAD_0001, 1'b0);
        #1;
        check_val("clr2", {31'd0, buf_clear}, 32'd1);
        check_val("drain_req", {31'd0, bus_req}, 32'd0);
        check_val("drain_out", {30'd0, outstanding}, 32'd2);
        nxt();
        respond(32'h0, 32'hDEAD_0002, 1'b0);
        #1 check_val("drain_req2", {31'd0, bus_req}, 32'd0);
        nxt();
        bus_rvalid = 1'b0;
        #1;
        check_val("post_drain_req", {31'd0, bus_req}, 32'd1);
        check_val("post_drain_addr", bus_addr, 32'h0000_2000);
        nxt();
        respond(32'h0000_2000, 32'hBBBB_0001, 1'b1);
        #1 check_val("addr_2004", bus_addr, 32'h0000_2004);
        nxt();

        // Redirect coincident with the only outstanding response.
        redirect = 1'b1; redirect_pc = 32'h0000_3000; cur_pc = 32'h0000_3000;
        respond(32'h0, 32'hDEAD_0003, 1'b0);
        nxt();
        redirect = 1'b0; bus_rvalid = 1'b0; bus_ack = 1'b0;
        #1;
        check_val("clr3", {31'd0, buf_clear}, 32'd1);
        check_val("coinc_out", {30'd0, outstanding}, 32'd0);
        check_val("coinc_req", {31'd0, bus_req}, 32'd1);
        check_val("coinc_addr", bus_addr, 32'h0000_3000);
        nxt();
        #1;
        check_val("hold_req", {31'd0, bus_req}, 32'd1);
        check_val("hold_addr", bus_addr, 32'h0000_3000);

        // Address wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; cur_pc = 32'hFFFF_FFFC;
        nxt();
        redirect = 1'b0; bus_ack = 1'b1;
        #1 check_val("wrap_addr0", bus_addr, 32'hFFFF_FFFC);
        nxt();
        respond(32'hFFFF_FFFC, 32'hCCCC_0001, 1'b1);
        #1;
        check_val("wrap_req1", {31'd0, bus_req}, 32'd1);
        check_val("wrap_addr1", bus_addr, 32'h0000_0000);
        nxt();
        respond(32'h0000_0000, 32'hCCCC_0002, 1'b1);
        #1 check_val("wrap_block", {31'd0, bus_req}, 32'd0);
        nxt();
        bus_rvalid = 1'b0;
        cur_pc = 32'h0000_0004;
        #1 check_val("wrap_out", {30'd0, outstanding}, 32'd0);
        nxt();
        nxt();
        #1 check_val("fill_out", {30'd0, outstanding}, 32'd2);

        // Reset during DRAIN, concurrent with a redirect and a response.
        redirect = 1'b1; redirect_pc = 32'h0000_5000;
        nxt();
        #1 check_val("drain2_clr", {31'd0, buf_clear}, 32'd1);
        rest = 1'b1; redirect_pc = 32'h0000_6000;
        respond(32'h0, 32'hDEAD_0004, 1'b0);
        nxt();
        rest = 1'b0; redirect = 1'b0; bus_rvalid = 1'b0;
        #1;
        check_reset_outputs("rst2");
        repeat (3) nxt();
        check_val("idle_after_rst", {31'd0, bus_req}, 32'd0);

        // Stray response with nothing outstanding.
        respond(32'h0, 32'hDEAD_0005, 1'b0);
        nxt();
        bus_rvalid = 1'b0;
        #1 check_val("stray_out", {30'd0, outstanding}, 32'd0);
        repeat (2) nxt();
        check_val("sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
